// File: rtl/line_mirror_ctrl.sv
// Address/bank sequencer for a two-bank ping-pong line RAM: writes each line
// ascending into one bank while the previous line is read back from the other.
module line_mirror_ctrl #(
  parameter int LINE_W = 640,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              iCCD_PIXCLK,
  input  logic              iRST_N,
  input  logic              iCCD_DVAL,
  input  logic              iMIRROR_EN,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oWR_BANK,
  output logic              oRD_EN,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oRD_BANK,
  output logic              oDVAL,
  output logic              oOVF,
  output logic              oDROP
);

  // One extra bit so the write counter can hold LINE_W itself.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LINE_MAX = CNT_W'(LINE_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  rd_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_wr_cnt, r_rd_cnt, r_rd_len;
  logic              r_wr_bank, r_rd_bank, r_dval_d;
  logic              r_line_mirror, r_rd_mirror, r_ovf_seen, r_drop;
  logic [RD_LAT-1:0] r_dval_pipe;

  logic              w_line_start, w_line_end, w_wr_en, w_ovf;
  logic              w_rd_en, w_rd_last, w_accept;
  logic [CNT_W-1:0]  w_rd_last_idx;

  assign w_line_start  = iCCD_DVAL && !r_dval_d;
  assign w_line_end    = !iCCD_DVAL && r_dval_d;
  // Gated by reset so every output reads 0 while reset is held.
  assign w_wr_en       = iRST_N && iCCD_DVAL && (r_wr_cnt < LINE_MAX);
  assign w_ovf         = iRST_N && iCCD_DVAL && (r_wr_cnt == LINE_MAX) && !r_ovf_seen;
  assign w_rd_en       = (r_state == RD_READ);
  assign w_rd_last_idx = r_rd_len - CNT_ONE;
  assign w_rd_last     = w_rd_en && (r_rd_cnt == w_rd_last_idx);
  // The cycle carrying the last read address can already accept a new line.
  assign w_accept      = w_line_end && (!w_rd_en || w_rd_last);

  assign oWR_EN   = w_wr_en;
  assign oWR_ADDR = ADDR_W'(r_wr_cnt);
  assign oWR_BANK = r_wr_bank;
  assign oOVF     = w_ovf;
  assign oRD_EN   = w_rd_en;
  assign oRD_ADDR = !w_rd_en ? '0
                  : ADDR_W'(r_rd_mirror ? (w_rd_last_idx - r_rd_cnt) : r_rd_cnt);
  assign oRD_BANK = r_rd_bank;
  assign oDVAL    = r_dval_pipe[RD_LAT-1];
  assign oDROP    = r_drop;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (w_accept) w_state_nxt = RD_READ;
      RD_READ: if (w_rd_last && !w_accept) w_state_nxt = RD_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state       <= RD_IDLE;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_rd_len      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_dval_d      <= 1'b0;
      r_line_mirror <= 1'b0;
      r_rd_mirror   <= 1'b0;
      r_ovf_seen    <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dval_d <= iCCD_DVAL;
      r_drop   <= w_line_end && !w_accept;

      if (w_line_start) r_line_mirror <= iMIRROR_EN;

      if (w_line_end) begin
        r_wr_cnt   <= '0;
        r_ovf_seen <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_cnt   <= r_wr_cnt + CNT_ONE;
        if (w_ovf)   r_ovf_seen <= 1'b1;
      end

      // A dropped line leaves wr_bank alone so the next line reuses that bank.
      if (w_accept) begin
        r_rd_len    <= r_wr_cnt;
        r_rd_mirror <= r_line_mirror;
        r_rd_bank   <= r_wr_bank;
        r_rd_cnt    <= '0;
        r_wr_bank   <= !r_wr_bank;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
    end
  end

  // NOTE: the latency pipe is plain flops, so it is cleared by reset to kill in-flight valids.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_dval_pipe <= '0;
    end else begin
      r_dval_pipe[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_dval_pipe[i] <= r_dval_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_line_mirror_ctrl.sv
// Bench for line_mirror_ctrl: directed lines plus random short lines, checked
// every cycle against a line-level schedule model of the expected RAM accesses.
module tb_line_mirror_ctrl;

  localparam int LINE_W = 640;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 1;
  localparam int MAXC   = 16384;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              dval  = 1'b0;
  logic              mir   = 1'b0;
  logic              oWR_EN, oWR_BANK, oRD_EN, oRD_BANK, oDVAL, oOVF, oDROP;
  logic [ADDR_W-1:0] oWR_ADDR, oRD_ADDR;

  always #5 clk = ~clk;

  line_mirror_ctrl #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .iCCD_PIXCLK(clk),
    .iRST_N     (rst_n),
    .iCCD_DVAL  (dval),
    .iMIRROR_EN (mir),
    .oWR_EN     (oWR_EN),
    .oWR_ADDR   (oWR_ADDR),
    .oWR_BANK   (oWR_BANK),
    .oRD_EN     (oRD_EN),
    .oRD_ADDR   (oRD_ADDR),
    .oRD_BANK   (oRD_BANK),
    .oDVAL      (oDVAL),
    .oOVF       (oOVF),
    .oDROP      (oDROP)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected read-side activity, indexed by absolute cycle number.
  bit   s_rd_en   [MAXC];
  int   s_rd_addr [MAXC];
  bit   s_rd_bank [MAXC];
  bit   s_dval    [MAXC];
  bit   s_drop    [MAXC];

  int m_pix     = 0;   // DVAL cycles seen in the current line (not saturated)
  bit m_prev    = 1'b0;
  bit m_bank    = 1'b0;
  bit m_lmir    = 1'b0;
  int m_last_rd = -1;  // cycle holding the last read address of the active read

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    int wcnt;
    int len;
    wcnt = (m_pix > LINE_W) ? LINE_W : m_pix;
    if (dval && !m_prev) m_lmir = mir;

    check("wr_en",   32'(oWR_EN),   32'(dval && (m_pix < LINE_W)));
    check("wr_addr", 32'(oWR_ADDR), 32'(wcnt));
    check("wr_bank", 32'(oWR_BANK), 32'(m_bank));
    check("ovf",     32'(oOVF),     32'(dval && (m_pix == LINE_W)));
    check("rd_en",   32'(oRD_EN),   32'(s_rd_en[cyc]));
    if (s_rd_en[cyc]) begin
      check("rd_addr", 32'(oRD_ADDR), 32'(s_rd_addr[cyc]));
      check("rd_bank", 32'(oRD_BANK), 32'(s_rd_bank[cyc]));
      check("bank_sep", 32'(oWR_EN && (oWR_BANK == oRD_BANK)), 32'(0));
    end
    check("dval_out", 32'(oDVAL), 32'(s_dval[cyc]));
    check("drop",     32'(oDROP), 32'(s_drop[cyc]));

    if (dval) m_pix++;
    if (!dval && m_prev) begin
      len = (m_pix > LINE_W) ? LINE_W : m_pix;
      if (cyc >= m_last_rd) begin
        for (int k = 0; k < len; k++) begin
          s_rd_en  [cyc+1+k]        = 1'b1;
          s_rd_addr[cyc+1+k]        = m_lmir ? (len - 1 - k) : k;
          s_rd_bank[cyc+1+k]        = m_bank;
          s_dval   [cyc+1+k+RD_LAT] = 1'b1;
        end
        m_last_rd = cyc + len;
        m_bank    = !m_bank;
      end else begin
        s_drop[cyc+1] = 1'b1;
      end
      m_pix = 0;
    end
    m_prev = dval;
  endtask

  task automatic step(input bit d, input bit m);
    @(negedge clk);
    dval = d;
    mir  = m;
    #1;
    model_cycle();
    cyc++;
  endtask

  task automatic send_line(input int len, input bit m0, input int tog_at);
    for (int i = 0; i < len; i++)
      step(1'b1, (tog_at >= 0 && i >= tog_at) ? !m0 : m0);
  endtask

  task automatic gap(input int g);
    for (int i = 0; i < g; i++) step(1'b0, 1'($urandom));
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      dval  = 1'b0;
      #1;
      check("rst_wr_en",   32'(oWR_EN),   32'(0));
      check("rst_wr_addr", 32'(oWR_ADDR), 32'(0));
      check("rst_wr_bank", 32'(oWR_BANK), 32'(0));
      check("rst_rd_en",   32'(oRD_EN),   32'(0));
      check("rst_rd_addr", 32'(oRD_ADDR), 32'(0));
      check("rst_rd_bank", 32'(oRD_BANK), 32'(0));
      check("rst_dval",    32'(oDVAL),    32'(0));
      check("rst_ovf",     32'(oOVF),     32'(0));
      check("rst_drop",    32'(oDROP),    32'(0));
      cyc++;
    end
    for (int i = cyc; i < MAXC; i++) begin
      s_rd_en[i]   = 1'b0;
      s_rd_addr[i] = 0;
      s_rd_bank[i] = 1'b0;
      s_dval[i]    = 1'b0;
      s_drop[i]    = 1'b0;
    end
    m_pix     = 0;
    m_prev    = 1'b0;
    m_bank    = 1'b0;
    m_lmir    = 1'b0;
    m_last_rd = -1;
    rst_n     = 1'b1;
  endtask

  initial begin
    int len;
    do_reset(3);

    // Full mirrored line, then next line lands in bank 1 while bank 0 is read.
    send_line(640, 1'b1, -1);  gap(100);
    // In-order line with a mid-line mirror toggle, then a line sampling the new value.
    send_line(640, 1'b0, 320); gap(700);
    send_line(640, 1'b1, -1);  gap(700);
    // Short mirrored line.
    send_line(10, 1'b1, -1);   gap(20);
    // Overlong line: 640 writes, one overflow pulse at pixel 641.
    send_line(700, 1'b0, -1);  gap(700);
    // Second line ends mid-read and is dropped; third line reuses its bank.
    send_line(640, 1'b1, -1);  gap(1);
    send_line(20, 1'b0, -1);   gap(700);
    send_line(30, 1'b1, -1);   gap(50);
    // Line end coinciding with the last read address: back-to-back, no drop.
    send_line(10, 1'b0, -1);   gap(1);
    send_line(9, 1'b1, -1);    gap(30);
    // Single-pixel line.
    send_line(1, 1'b1, -1);    gap(5);
    // Reset in the middle of a read (rd_cnt = 300), then a clean line.
    send_line(640, 1'b1, -1);  gap(301);
    do_reset(2);
    send_line(640, 1'b1, -1);  gap(700);

    // Random short lines and gaps: exercises drops and back-to-back reads.
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 40);
      send_line(len, 1'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1);
      gap($urandom_range(1, 30));
    end
    gap(100);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
